qs_fifo_drain: RTL and testbench

- Pop-side adapter for the team's synchronous FIFO.
- Watches the FIFO's empty flag, issues pops, and captures the combinational pop data on the same cycle.
- Presents the words as a registered valid/ready stream with a 2-entry skid buffer and burst framing (`out_last_o` every BURST_LEN beats).
- Sits between a qs_fifo instance and any downstream stream consumer. No combinational path from `out_ready_i` to `fifo_pop_o`.

---
 rtl/qs_fifo_drain_if.sv | 36 +++
 rtl/qs_fifo_drain.sv | 146 ++++++++++++++
 tb/tb_qs_fifo_drain.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qs_fifo_drain_if.sv
// ---------------------------------------------------------------------------
// qs_fifo_drain_if
// Bundles the FIFO pop side and the downstream valid/ready stream of the
// qs_fifo_drain adapter.
//
//   fifo_empty_i  FIFO empty flag (into the drain)
//   fifo_pop_o    pop request to the FIFO (out of the drain)
//   fifo_data_i   FIFO pop data; meaningful only while popping a non-empty FIFO
//   out_valid_o   output word available
//   out_ready_i   downstream accepts the word
//   out_data_o    output word (head of the skid buffer)
//   out_last_o    final beat of the current burst
//
// Modports: master = the drain itself, slave = the FIFO/consumer environment.
// ---------------------------------------------------------------------------
interface qs_fifo_drain_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty_i;
  logic              fifo_pop_o;
  logic [DATA_W-1:0] fifo_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_pop_o, out_valid_o, out_data_o, out_last_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_pop_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/qs_fifo_drain.sv
// ---------------------------------------------------------------------------
// qs_fifo_drain
// Pop-side adapter for a synchronous FIFO. Pops words whenever there is room
// in a 2-entry skid buffer, captures the combinational pop data on the same
// edge, and presents the words as a registered valid/ready stream framed into
// bursts of BURST_LEN beats (out_last_o on the final beat of each burst).
//
// Parameters:
//   DATA_W     width of FIFO words and output data
//   BURST_LEN  output beats per burst (>= 1)
//
// Ports:
//   clk         clock, all state on the rising edge
//   reset       asynchronous, active-high reset
//   flush_i     synchronous flush of the buffer and burst counter
//   bus         qs_fifo_drain_if.master (FIFO pop side + output stream)
//   word_cnt_o  [15:0] completed-handshake counter, present only when the
//               macro QS_DRAIN_CNT_EN is defined
//
// The pop request depends only on registered state and the FIFO flag, so
// there is no combinational path from out_ready_i to fifo_pop_o.
// ---------------------------------------------------------------------------
module qs_fifo_drain #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  qs_fifo_drain_if.master     bus
`ifdef QS_DRAIN_CNT_EN
  ,
  output logic [15:0]         word_cnt_o
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;

  logic pop;
  logic deq;
  logic out_valid;

  assign out_valid = (count_q != 2'd0);

  // Reset is included so the pop is suppressed even before the async clear
  // of count_q has propagated.
  assign pop = !reset && !bus.fifo_empty_i && (count_q < 2'd2) && !flush_i;
  assign deq = out_valid && bus.out_ready_i;

  // Next-state of the skid buffer and burst counter. A pop lands in the first
  // slot that is free once a same-cycle dequeue has been taken into account.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    beat_d  = beat_q;

    if (flush_i) begin
      // Words in the buffer are dropped; a coinciding handshake is not counted.
      count_d = 2'd0;
      beat_d  = '0;
    end else begin
      case (count_q)
        2'd0: begin
          if (pop) begin
            slot0_d = bus.fifo_data_i;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (pop && !deq) begin
            slot1_d = bus.fifo_data_i;
            count_d = 2'd2;
          end else if (pop && deq) begin
            slot0_d = bus.fifo_data_i;
          end else if (deq) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (deq) begin
            slot0_d = slot1_q;
            count_d = 2'd1;
          end
        end
        default: begin
          count_d = 2'd0;
        end
      endcase

      if (deq) begin
        beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
      beat_q  <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.fifo_pop_o  = pop;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = slot0_q;
  assign bus.out_last_o  = out_valid && (beat_q == LAST_BEAT);

`ifdef QS_DRAIN_CNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  // Flush takes priority over a same-cycle handshake; wraps naturally.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (flush_i) begin
      word_cnt_d = 16'd0;
    end else if (deq) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q <= 16'd0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_qs_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_qs_fifo_drain
// Directed bench for qs_fifo_drain (DATA_W=8, BURST_LEN=4). A queue stands in
// for the FIFO: its head is offered as fifo_data_i and removed at an edge
// where the drain asserted fifo_pop_o.
// ---------------------------------------------------------------------------
module tb_qs_fifo_drain;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush_i;

  qs_fifo_drain_if #(.DATA_W(DATA_W)) bus ();

`ifdef QS_DRAIN_CNT_EN
  logic [15:0] word_cnt;
`endif

  qs_fifo_drain #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .bus     (bus)
`ifdef QS_DRAIN_CNT_EN
    ,
    .word_cnt_o (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fifo_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic              obs_pop;
  logic              obs_valid;
  logic              obs_last;
  logic              obs_deq;
  logic [DATA_W-1:0] obs_data;

  // One clock cycle: drive inputs just after an edge, sample the settled
  // outputs 1 time unit later, then advance past the next rising edge and
  // retire the FIFO head if it was popped.
  task automatic step(input logic rdy, input logic fl);
    bus.out_ready_i  = rdy;
    flush_i          = fl;
    bus.fifo_empty_i = (fifo_q.size() == 0);
    bus.fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    obs_pop   = bus.fifo_pop_o;
    obs_valid = bus.out_valid_o;
    obs_last  = bus.out_last_o;
    obs_data  = bus.out_data_o;
    obs_deq   = bus.out_valid_o && rdy;
    @(posedge clk);
    #1;
    if (obs_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    flush_i          = 1'b0;
    bus.out_ready_i  = 1'b0;
    bus.fifo_empty_i = 1'b0;
    bus.fifo_data_i  = 8'hEE;
    #12;
    n_cmp++;
    if (bus.fifo_pop_o !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_pop got=%b exp=0", bus.fifo_pop_o);
    end
    n_cmp++;
    if (bus.out_valid_o !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.out_valid_o);
    end
    n_cmp++;
    if (bus.out_data_o !== 8'h00) begin
      n_bad++; $display("[TB] FAIL reset_data got=%h exp=00", bus.out_data_o);
    end
    n_cmp++;
    if (bus.out_last_o !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_last got=%b exp=0", bus.out_last_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs_valid !== 1'b0 || obs_pop !== 1'b0) begin
      n_bad++; $display("[TB] FAIL idle_after_reset got valid=%b pop=%b exp 0/0", obs_valid, obs_pop);
    end
  endtask

  task automatic test_basic_latency();
    bit                exp_pop   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit                exp_valid [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DATA_W-1:0] exp_data  [5] = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    fifo_q.push_back(8'hA3);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (obs_pop !== exp_pop[c]) begin
        n_bad++; $display("[TB] FAIL basic_pop cyc=%0d got=%b exp=%b", c, obs_pop, exp_pop[c]);
      end
      n_cmp++;
      if (obs_valid !== exp_valid[c]) begin
        n_bad++; $display("[TB] FAIL basic_valid cyc=%0d got=%b exp=%b", c, obs_valid, exp_valid[c]);
      end
      if (exp_valid[c]) begin
        n_cmp++;
        if (obs_data !== exp_data[c] || obs_last !== 1'b0) begin
          n_bad++; $display("[TB] FAIL basic_beat cyc=%0d got=%h/%b exp=%h/0", c, obs_data, obs_last, exp_data[c]);
        end
      end
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int pops = 0;
    int got  = 0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h10 + i));
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0);
      if (obs_pop) pops++;
      if (c >= 1) begin
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h10) begin
          n_bad++; $display("[TB] FAIL bp_hold cyc=%0d got=%b/%h exp=1/10", c, obs_valid, obs_data);
        end
      end
    end
    n_cmp++;
    if (pops != 2) begin
      n_bad++; $display("[TB] FAIL bp_pops got=%0d exp=2", pops);
    end
    for (int c = 0; c < 20 && got < 5; c++) begin
      step(1'b1, 1'b0);
      if (obs_deq) begin
        n_cmp++;
        if (obs_data !== 8'(8'h10 + got)) begin
          n_bad++; $display("[TB] FAIL bp_order beat=%0d got=%h exp=%h", got, obs_data, 8'(8'h10 + got));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 5) begin
      n_bad++; $display("[TB] FAIL bp_count got=%0d exp=5", got);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_burst_framing();
    int  beats = 0;
    logic exp_last;
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h20 + i));
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        fifo_q.push_back(8'h2A);
        fifo_q.push_back(8'h2B);
      end
      for (int c = 0; c < 30 && beats < 10 + 2 * phase; c++) begin
        step(1'b1, 1'b0);
        if (obs_deq) begin
          beats++;
          exp_last = (beats == 4 || beats == 8 || beats == 12);
          n_cmp++;
          if (obs_last !== exp_last || obs_data !== 8'(8'h20 + beats - 1)) begin
            n_bad++; $display("[TB] FAIL burst_beat beat=%0d got last=%b data=%h exp last=%b data=%h",
                              beats, obs_last, obs_data, exp_last, 8'(8'h20 + beats - 1));
          end
        end
      end
    end
    n_cmp++;
    if (beats != 12) begin
      n_bad++; $display("[TB] FAIL burst_count got=%0d exp=12", beats);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_random_stall();
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_w;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_stall = 1'b0;
    logic              rdy;
    int                got = 0;
    for (int i = 0; i < 200; i++) begin
      fifo_q.push_back(8'(i * 7 + 3));
      exp_q.push_back(8'(i * 7 + 3));
    end
    for (int c = 0; c < 2000 && got < 200; c++) begin
      rdy = 1'($urandom_range(0, 1));
      step(rdy, 1'b0);
      if (prev_stall) begin
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
          n_bad++; $display("[TB] FAIL stall_stable cyc=%0d got=%b/%h exp=1/%h", c, obs_valid, obs_data, prev_data);
        end
      end
      if (obs_deq) begin
        exp_w = exp_q.pop_front();
        n_cmp++;
        if (obs_data !== exp_w) begin
          n_bad++; $display("[TB] FAIL rand_order beat=%0d got=%h exp=%h", got, obs_data, exp_w);
        end
        got++;
      end
      prev_stall = obs_valid && !rdy;
      prev_data  = obs_data;
    end
    n_cmp++;
    if (got != 200) begin
      n_bad++; $display("[TB] FAIL rand_count got=%0d exp=200", got);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] exp_data [4] = '{8'hD2, 8'hE0, 8'hE1, 8'hE2};
    int got = 0;
    fifo_q.push_back(8'hC0);
    fifo_q.push_back(8'hC1);
    for (int c = 0; c < 10 && got < 2; c++) begin
      step(1'b1, 1'b0);
      if (obs_deq) got++;
    end
    fifo_q.push_back(8'hD0);
    fifo_q.push_back(8'hD1);
    fifo_q.push_back(8'hD2);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_data !== 8'hD0 || got != 2) begin
      n_bad++; $display("[TB] FAIL flush_setup got=%b/%h beats=%0d exp=1/d0 beats=2", obs_valid, obs_data, got);
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (obs_pop !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flush_nopop got=%b exp=0", obs_pop);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs_valid !== 1'b0 || obs_pop !== 1'b1) begin
      n_bad++; $display("[TB] FAIL flush_after got valid=%b pop=%b exp 0/1", obs_valid, obs_pop);
    end
    fifo_q.push_back(8'hE0);
    fifo_q.push_back(8'hE1);
    fifo_q.push_back(8'hE2);
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      step(1'b1, 1'b0);
      if (obs_deq) begin
        n_cmp++;
        if (obs_data !== exp_data[got] || obs_last !== (got == 3)) begin
          n_bad++; $display("[TB] FAIL flush_restart beat=%0d got=%h/%b exp=%h/%b",
                            got, obs_data, obs_last, exp_data[got], (got == 3));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_bad++; $display("[TB] FAIL flush_restart_count got=%0d exp=4", got);
    end
    // Flush while holding one word and the FIFO could supply another.
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'hF1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pop !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flush_cnt1_pop got valid=%b pop=%b exp 1/0", obs_valid, obs_pop);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_data !== 8'hF1) begin
      n_bad++; $display("[TB] FAIL flush_cnt1_next got=%b/%h exp=1/f1", obs_valid, obs_data);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] exp_data [3] = '{8'h92, 8'h93, 8'h94};
    int got = 0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h90 + i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid_o !== 1'b0 || bus.out_last_o !== 1'b0 || bus.out_data_o !== 8'h00) begin
      n_bad++; $display("[TB] FAIL async_reset got=%b/%b/%h exp=0/0/00",
                        bus.out_valid_o, bus.out_last_o, bus.out_data_o);
    end
    n_cmp++;
    if (bus.fifo_pop_o !== 1'b0) begin
      n_bad++; $display("[TB] FAIL async_reset_pop got=%b exp=0", bus.fifo_pop_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef QS_DRAIN_CNT_EN
    n_cmp++;
    if (word_cnt !== 16'd0) begin
      n_bad++; $display("[TB] FAIL cnt_after_reset got=%0d exp=0", word_cnt);
    end
`endif
    fifo_q.push_back(8'h94);
    for (int c = 0; c < 12 && got < 3; c++) begin
      step(1'b1, 1'b0);
      if (obs_deq) begin
        n_cmp++;
        if (obs_data !== exp_data[got] || obs_last !== 1'b0) begin
          n_bad++; $display("[TB] FAIL post_reset beat=%0d got=%h/%b exp=%h/0", got, obs_data, obs_last, exp_data[got]);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 3) begin
      n_bad++; $display("[TB] FAIL post_reset_count got=%0d exp=3", got);
    end
`ifdef QS_DRAIN_CNT_EN
    n_cmp++;
    if (word_cnt !== 16'd3) begin
      n_bad++; $display("[TB] FAIL cnt_three got=%0d exp=3", word_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_backpressure();
    test_burst_framing();
    test_random_stall();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
